// File: rtl/reaction_game_fsm_pkg.sv
// Shared definitions for the reaction-time game: screen encodings seen by the
// VGA controller, the score ceiling and the game state type.
package react_pkg;

  localparam logic [1:0] SCR_BLUE  = 2'd0;
  localparam logic [1:0] SCR_RED   = 2'd1;
  localparam logic [1:0] SCR_GREEN = 2'd2;
  localparam logic [1:0] SCR_SCORE = 2'd3;

  localparam logic [11:0] SCORE_MAX = 12'd4095;

  // The state encoding doubles as the screen selector, so the output needs no decode.
  typedef enum logic [1:0] {
    ST_BLUE  = SCR_BLUE,
    ST_RED   = SCR_RED,
    ST_GREEN = SCR_GREEN,
    ST_SCORE = SCR_SCORE
  } game_state_t;

endpackage

// File: rtl/reaction_game_fsm_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used to randomise the
// red-screen wait. A non-zero seed keeps it out of the all-zero lock-up state.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        iReset,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic        feedback;

  assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Shift every cycle; reset reloads the seed.
  always_ff @(posedge clk) begin
    if (iReset) lfsr_q <= SEED;
    else        lfsr_q <= {lfsr_q[14:0], feedback};
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/reaction_game_fsm.sv
// Game control for the reaction-time benchmark: synchronises the player key,
// walks BLUE -> RED (random wait) -> GREEN (timed) -> SCORE, and reports the
// reaction time in whole milliseconds to the VGA drawing controller.
module reaction_game_fsm
  import react_pkg::*;
#(
  parameter int          CLK_HZ       = 50_000_000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 11,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        iReset,
  input  logic        keyPress,
  output logic [1:0]  reactScreen,
  output logic [11:0] currentScore,
  output logic        roundDone
);

  localparam int              TICK_DIV = CLK_HZ / 1000;
  localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(TICK_DIV - 1);

  // The random wait must fit the 12-bit delay counter and never start at zero.
  if (MIN_DELAY_MS + (1 << RAND_BITS) - 1 > 4095) begin : g_delay_range_err
    $error("reaction_game_fsm: MIN_DELAY_MS + 2**RAND_BITS - 1 exceeds 4095");
  end
  if (MIN_DELAY_MS < 1) begin : g_delay_zero_err
    $error("reaction_game_fsm: MIN_DELAY_MS must be at least 1");
  end
  if (LFSR_SEED == 16'h0000) begin : g_seed_err
    $error("reaction_game_fsm: LFSR_SEED must be non-zero");
  end

  logic        s1_q, s2_q, prev_q;
  logic        press;
  logic [PRE_W-1:0] pre_q;
  logic        tick;
  logic [15:0] lfsr_w;
  game_state_t state_q, state_d;
  logic [11:0] delay_q, delay_d;
  logic [11:0] ms_q, ms_d;
  logic [11:0] score_q, score_d;
  logic        done_q, done_d;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .iReset (iReset),
    .lfsr_o (lfsr_w)
  );

  // Two-flop synchroniser plus a history flop so a held key yields one event.
  always_ff @(posedge clk) begin
    if (iReset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= keyPress;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign press = s2_q & ~prev_q;
  assign tick  = (pre_q == PRE_TERM);

  // Millisecond prescaler, restarted on every state change so timing is entry-relative.
  always_ff @(posedge clk) begin
    if (iReset || (state_d != state_q) || tick) pre_q <= '0;
    else                                        pre_q <= pre_q + PRE_W'(1);
  end

  // State register together with the per-state counters and registered outputs.
  always_ff @(posedge clk) begin
    if (iReset) begin
      state_q <= ST_BLUE;
      delay_q <= '0;
      ms_q    <= '0;
      score_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      ms_q    <= ms_d;
      score_q <= score_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; a press always takes priority over a coincident tick.
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    ms_d    = ms_q;
    case (state_q)
      ST_BLUE: begin
        if (press) begin
          state_d = ST_RED;
          delay_d = 12'(MIN_DELAY_MS) + 12'(lfsr_w[RAND_BITS-1:0]);
        end
      end
      ST_RED: begin
        if (press) begin
          state_d = ST_BLUE;
        end else if (tick) begin
          if (delay_q == 12'd1) begin
            state_d = ST_GREEN;
            ms_d    = '0;
          end else begin
            delay_d = delay_q - 12'd1;
          end
        end
      end
      ST_GREEN: begin
        if (press) begin
          state_d = ST_SCORE;
        end else if (tick) begin
          if (ms_q != SCORE_MAX) ms_d = ms_q + 12'd1;
          if (ms_q == SCORE_MAX - 12'd1) state_d = ST_SCORE;
        end
      end
      ST_SCORE: begin
        if (press) state_d = ST_BLUE;
      end
      default: state_d = ST_BLUE;
    endcase
  end

  // Score and round-done pulse for the GREEN -> SCORE exit; the score holds otherwise.
  always_comb begin
    score_d = score_q;
    done_d  = 1'b0;
    if ((state_q == ST_GREEN) && (state_d == ST_SCORE)) begin
      done_d  = 1'b1;
      score_d = press ? ms_q : SCORE_MAX;
    end
  end

  assign reactScreen  = state_q;
  assign currentScore = score_q;
  assign roundDone    = done_q;

endmodule

// File: doc/reaction_game_fsm.md
# reaction_game_fsm

Game-control stage of the reaction-time benchmark, sitting directly upstream of the VGA drawing controller. It debounces-free synchronises the player key, sequences the game through start, wait, react and score screens, and times the player's reaction in milliseconds. It drives the screen selector and the 12-bit score that the VGA controller renders.

## Interface

**Parameters**
- `CLK_HZ`, default 50_000_000: clock frequency, used to derive the 1 ms tick.
- `MIN_DELAY_MS`, default 1000: fixed part of the random red-screen wait.
- `RAND_BITS`, default 11: width of the random wait addend, giving 0..2^RAND_BITS-1 ms.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be non-zero.

**Ports**
- `clk` in 1: system clock.
- `iReset` in 1: reset, synchronous, active-high.
- `keyPress` in 1: raw player key, active-high, asynchronous to `clk`.
- `reactScreen` out 2: screen select. 0 = BLUE (idle/start), 1 = RED (wait), 2 = GREEN (react), 3 = SCORE.
- `currentScore` out 12: last reaction time in ms, saturating at 4095.
- `roundDone` out 1: one-cycle pulse when a valid score is latched.

## Operation

- **Key synchroniser:** two flops `s1`, `s2`, plus `prev`. The press event is `s2 & ~prev`. Only rising edges count; a held key generates one event.
- **ms tick:** the prescaler counts 0..CLK_HZ/1000-1. `tick` is high in the cycle the count equals the terminal value, then the count wraps to 0. The prescaler is cleared on every state entry, so the first tick in a state lands exactly CLK_HZ/1000 cycles after entry.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. Shifts every cycle and is never zero.
- **States** (`reactScreen` is the registered state encoding):
  - **BLUE:** on a press event, go to RED. Load `delay = MIN_DELAY_MS + lfsr[RAND_BITS-1:0]`.
  - **RED:** on each `tick`, decrement `delay`. When `tick` arrives with `delay == 1`, go to GREEN. A press event in RED ("too soon") returns to BLUE and leaves `currentScore` unchanged. If a press and the final tick happen in the same cycle, the press wins and the state goes to BLUE.
  - **GREEN:** entry clears the `ms` counter to 0. Each `tick` increments `ms`, saturating at 4095.
    - A press event goes to SCORE: `currentScore <= ms`, and `roundDone` pulses.
    - If `ms` reaches 4095, go to SCORE automatically with `currentScore = 4095` and a `roundDone` pulse.
    - If a press and a tick happen in the same cycle, the score is the pre-increment `ms`.
  - **SCORE:** hold `currentScore`. A press event goes to BLUE.
- **Reset values:** `reactScreen = 0` (BLUE), `currentScore = 0`, `roundDone = 0`. The synchroniser flops, prescaler, `delay` and `ms` are all 0, and the LFSR is `LFSR_SEED`.
- **Reset mid-round:** reset in any state returns to BLUE within one edge, with the score cleared.
- **Internal widths:**
  - `delay`: 12 bits (MIN_DELAY_MS + max addend ≤ 4095; checked with an elaboration-time assertion).
  - `ms`: 12 bits.
  - Prescaler: `$clog2(CLK_HZ/1000)` bits.

## Timing

- **Key to screen:** when `keyPress` rises before clock edge k, the press event is high in the cycle after edge k+1. The state and `reactScreen` update at edge k+2.
- **RED duration:** exactly `delay × CLK_HZ/1000` cycles from RED entry to GREEN entry, ±0 cycles.
- **Score resolution:** the score counts whole ms elapsed between GREEN entry and the registered press event. Synchroniser latency (2 cycles) is not compensated.
- **Output timing:** `roundDone` is registered and is high in the same cycle that `reactScreen` first reads 3. `currentScore` is valid from that same cycle.
- **Downstream contract:** all outputs are registered and stable between state changes. The downstream controller samples them freely once per frame.

## Structure

- **Package `react_pkg`:** screen encoding constants (SCR_BLUE=0, SCR_RED=1, SCR_GREEN=2, SCR_SCORE=3) and `SCORE_MAX = 12'd4095`. The VGA controller imports the same constants.
- **Sub-module `lfsr16`:** parameterised seed, free-running, with a 16-bit output.
- **Kept inline:** the prescaler and the key synchroniser.

## Test plan

Benches use CLK_HZ=4000 (4 cycles/ms), MIN_DELAY_MS=3, RAND_BITS=2.

- **Reset then idle:** assert `iReset` 2 cycles, release, no key → `reactScreen=0` and `currentScore=0` held for 100 cycles.
- **Full round:** press in BLUE → RED 2 edges later. GREEN after exactly (3+lfsr[1:0])×4 cycles. Press 21 cycles after GREEN entry → SCORE with `currentScore=5` and a one-cycle `roundDone`.
- **Too soon:** press 2 cycles after RED entry → BLUE, `currentScore` keeps its previous value, no `roundDone`.
- **Timeout:** enter GREEN with no press → after 4095×4 cycles go to SCORE with `currentScore=4095` and `roundDone` pulsed.
- **Held key and simultaneous events:**
  - Holding the key high for 50 cycles produces a single transition.
  - A press aligned with the final RED tick yields BLUE, not GREEN.
- **Reset mid-GREEN:** reset at ms=7 → next edge `reactScreen=0`, `currentScore=0`, LFSR back to the seed.
